// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Double-buffered value with frame-boundary swap and optional leading-zero blanking.
module display_scan_mux #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   data_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              nibble_o,
  output logic [N_DIGITS-1:0]     anode_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int unsigned DATA_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_active;
  logic [DATA_W-1:0] r_shadow;
  logic              r_pending;
  logic              r_frame;

  logic              w_tick;
  logic              w_wrap;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic              w_run_zero;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IDX_W'(N_DIGITS - 1));

  // Scan counters, shadow buffer and frame-boundary swap; a load issued on
  // the swap edge overrides the pending clear so the new data waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wrap && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
      if (load_i) begin
        r_shadow  <= data_i;
        r_pending <= 1'b1;
      end
    end
  end

  // Select current digit; blank it when it and every more-significant digit are zero.
  always_comb begin
    w_digit    = 4'h0;
    w_blank    = 1'b0;
    w_run_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_run_zero = w_run_zero && (r_active[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_digit = r_active[4*k +: 4];
        w_blank = blank_lz_i && (k != 0) && w_run_zero;
      end
    end
  end

  assign anode_o   = w_blank ? '1 : ~(N_DIGITS'(1) << r_idx);
  assign nibble_o  = w_blank ? 4'hF : w_digit;
  assign frame_o   = r_frame;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (N_DIGITS=4, REFRESH_DIV=4): directed
// stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_display_scan_mux;

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [3:0]  nibble_o;
  logic [3:0]  anode_o;
  logic        frame_o;
  logic        pending_o;

  int cyc;
  int n_checks;
  int n_errors;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] nib;
    logic       fr;
    logic       pend;
    string      tag;
  } exp_t;

  exp_t q[$];

  display_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .nibble_o   (nibble_o),
    .anode_o    (anode_o),
    .frame_o    (frame_o),
    .pending_o  (pending_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Queue expectations for cycles c0..c1; the frame bit applies to c0 only.
  task automatic push_rng(input int c0, input int c1, input logic [3:0] an,
                          input logic [3:0] nib, input logic fr, input logic pend,
                          input string tag);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc  = c;
      e.an   = an;
      e.nib  = nib;
      e.fr   = (c == c0) ? fr : 1'b0;
      e.pend = pend;
      e.tag  = tag;
      q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation on the negedge of its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: expectation for cyc %0d not sampled (now cyc %0d)", e.tag, e.cyc, cyc);
      end else if (anode_o !== e.an || nibble_o !== e.nib || frame_o !== e.fr || pending_o !== e.pend) begin
        n_errors++;
        $display("FAIL %s cyc=%0d: got an=%b nib=%h fr=%b pend=%b, want an=%b nib=%h fr=%b pend=%b",
                 e.tag, cyc, anode_o, nibble_o, frame_o, pending_o, e.an, e.nib, e.fr, e.pend);
      end
    end
  end

  initial begin
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    data_i     = 16'h0;
    load_i     = 1'b0;
    blank_lz_i = 1'b0;

    // Reset and first digit advance
    push_rng(3, 3, 4'b1110, 4'h0, 1'b0, 1'b0, "reset");
    push_rng(4, 6, 4'b1110, 4'h0, 1'b0, 1'b0, "rst_idx0");
    push_rng(7, 10, 4'b1101, 4'h0, 1'b0, 1'b0, "rst_idx1");
    wait_cyc(3);
    rst = 1'b0;

    // Scan order with 1A2F
    wait_cyc(10);
    data_i = 16'h1A2F;
    load_i = 1'b1;
    push_rng(11, 14, 4'b1011, 4'h0, 1'b0, 1'b1, "scan_pend2");
    push_rng(15, 18, 4'b0111, 4'h0, 1'b0, 1'b1, "scan_pend3");
    push_rng(19, 22, 4'b1110, 4'hF, 1'b1, 1'b0, "scan_d0");
    push_rng(23, 26, 4'b1101, 4'h2, 1'b0, 1'b0, "scan_d1");
    push_rng(27, 30, 4'b1011, 4'hA, 1'b0, 1'b0, "scan_d2");
    push_rng(31, 34, 4'b0111, 4'h1, 1'b0, 1'b0, "scan_d3");
    push_rng(35, 38, 4'b1110, 4'hF, 1'b1, 1'b0, "scan_f2d0");
    push_rng(39, 42, 4'b1101, 4'h2, 1'b0, 1'b0, "scan_f2d1");
    wait_cyc(11);
    load_i = 1'b0;

    // No tearing: load 1234 at idx 2
    wait_cyc(42);
    data_i = 16'h1234;
    load_i = 1'b1;
    push_rng(43, 46, 4'b1011, 4'hA, 1'b0, 1'b1, "tear_old2");
    push_rng(47, 50, 4'b0111, 4'h1, 1'b0, 1'b1, "tear_old3");
    push_rng(51, 54, 4'b1110, 4'h4, 1'b1, 1'b0, "tear_new0");
    push_rng(55, 58, 4'b1101, 4'h3, 1'b0, 1'b0, "tear_new1");
    wait_cyc(43);
    load_i = 1'b0;

    // Leading-zero blanking with 0070
    wait_cyc(58);
    data_i     = 16'h0070;
    load_i     = 1'b1;
    blank_lz_i = 1'b1;
    push_rng(59, 62, 4'b1011, 4'h2, 1'b0, 1'b1, "lz_old2");
    push_rng(63, 66, 4'b0111, 4'h1, 1'b0, 1'b1, "lz_old3");
    push_rng(67, 70, 4'b1110, 4'h0, 1'b1, 1'b0, "lz70_d0");
    push_rng(71, 74, 4'b1101, 4'h7, 1'b0, 1'b0, "lz70_d1");
    wait_cyc(59);
    load_i = 1'b0;

    // Blanking with 0000
    wait_cyc(74);
    data_i = 16'h0000;
    load_i = 1'b1;
    push_rng(75, 78, 4'b1111, 4'hF, 1'b0, 1'b1, "lz70_d2");
    push_rng(79, 82, 4'b1111, 4'hF, 1'b0, 1'b1, "lz70_d3");
    push_rng(83, 86, 4'b1110, 4'h0, 1'b1, 1'b0, "lz0_d0");
    push_rng(87, 90, 4'b1111, 4'hF, 1'b0, 1'b0, "lz0_d1");
    push_rng(91, 94, 4'b1111, 4'hF, 1'b0, 1'b0, "lz0_d2");
    push_rng(95, 98, 4'b1111, 4'hF, 1'b0, 1'b0, "lz0_d3");
    push_rng(99, 102, 4'b1110, 4'h0, 1'b1, 1'b0, "lz0_f6d0");
    wait_cyc(75);
    load_i = 1'b0;

    // Blanking disabled mid-frame takes effect immediately
    wait_cyc(102);
    blank_lz_i = 1'b0;
    push_rng(103, 106, 4'b1101, 4'h0, 1'b0, 1'b0, "nolz_d1");

    // Load A, then B exactly on the wrap tick
    wait_cyc(106);
    data_i = 16'hAAAA;
    load_i = 1'b1;
    push_rng(107, 110, 4'b1011, 4'h0, 1'b0, 1'b1, "swapA_pend2");
    push_rng(111, 114, 4'b0111, 4'h0, 1'b0, 1'b1, "swapA_pend3");
    wait_cyc(107);
    load_i = 1'b0;
    wait_cyc(114);
    data_i = 16'hBBBB;
    load_i = 1'b1;
    push_rng(115, 118, 4'b1110, 4'hA, 1'b1, 1'b1, "swapA_d0");
    push_rng(119, 122, 4'b1101, 4'hA, 1'b0, 1'b1, "swapA_d1");
    push_rng(123, 126, 4'b1011, 4'hA, 1'b0, 1'b1, "swapA_d2");
    push_rng(127, 130, 4'b0111, 4'hA, 1'b0, 1'b1, "swapA_d3");
    push_rng(131, 134, 4'b1110, 4'hB, 1'b1, 1'b0, "swapB_d0");
    push_rng(135, 138, 4'b1101, 4'hB, 1'b0, 1'b0, "swapB_d1");
    push_rng(139, 142, 4'b1011, 4'hB, 1'b0, 1'b0, "swapB_d2");
    push_rng(143, 146, 4'b0111, 4'hB, 1'b0, 1'b0, "swapB_d3");
    push_rng(147, 150, 4'b1110, 4'hB, 1'b1, 1'b0, "swapB_f9d0");
    wait_cyc(115);
    load_i = 1'b0;

    // Reset mid-frame discards pending 5555
    wait_cyc(150);
    data_i = 16'h5555;
    load_i = 1'b1;
    push_rng(151, 154, 4'b1101, 4'hB, 1'b0, 1'b1, "mrst_pend1");
    push_rng(155, 155, 4'b1011, 4'hB, 1'b0, 1'b1, "mrst_pend2");
    wait_cyc(151);
    load_i = 1'b0;
    wait_cyc(155);
    rst = 1'b1;
    push_rng(156, 160, 4'b1110, 4'h0, 1'b0, 1'b0, "mrst_d0");
    push_rng(161, 164, 4'b1101, 4'h0, 1'b0, 1'b0, "mrst_d1");
    push_rng(165, 168, 4'b1011, 4'h0, 1'b0, 1'b0, "mrst_d2");
    push_rng(169, 172, 4'b0111, 4'h0, 1'b0, 1'b0, "mrst_d3");
    push_rng(173, 176, 4'b1110, 4'h0, 1'b1, 1'b0, "mrst_f_d0");
    push_rng(177, 180, 4'b1101, 4'h0, 1'b0, 1'b0, "mrst_f_d1");
    push_rng(181, 184, 4'b1011, 4'h0, 1'b0, 1'b0, "mrst_f_d2");
    push_rng(185, 188, 4'b0111, 4'h0, 1'b0, 1'b0, "mrst_f_d3");
    wait_cyc(157);
    rst = 1'b0;

    wait_cyc(190);
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not end by cyc %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
